// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU/MTHI/MTLO unit with architectural HI/LO, one bit per cycle.
// Signed MULT/DIV support is compiled in only when MDU_SIGNED_EN is defined.
module mul_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             dz,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
  localparam logic [2:0]  OP_MTHI = 3'b100;
  localparam logic [2:0]  OP_MTLO = 3'b101;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   p_q, p_d;     // product high half / partial remainder
  logic [WIDTH-1:0]   q_q, q_d;     // multiplier / dividend, shifted into low product / quotient
  logic [WIDTH-1:0]   m_q, m_d;     // multiplicand / divisor magnitude
  logic               is_div_q, is_div_d;
  logic               busy_q, busy_d, done_q, done_d, dz_q, dz_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;

  logic               op_mul_c, op_div_c, div_zero_c;
  logic [WIDTH-1:0]   a_mag_c, b_mag_c;
  logic [WIDTH:0]     mul_sum_c, div_rsh_c;
  logic               div_ge_c;
  logic [WIDTH-1:0]   hi_step_c, lo_step_c, hi_res_c, lo_res_c;

  assign op_mul_c   = (op[2:1] == 2'b00);
  assign op_div_c   = (op[2:1] == 2'b01);
  assign div_zero_c = is_div_q && (m_q == '0);

`ifdef MDU_SIGNED_EN
  logic a_neg_q, a_neg_d, b_neg_q, b_neg_d;
  logic a_neg_c, b_neg_c;

  assign a_neg_c = op[0] & A[WIDTH-1];
  assign b_neg_c = op[0] & B[WIDTH-1];
  assign a_mag_c = a_neg_c ? -A : A;
  assign b_mag_c = b_neg_c ? -B : B;
`else
  assign a_mag_c = A;
  assign b_mag_c = B;
`endif

  // One shift-add (multiply) or restoring (divide) step on the current accumulator.
  always_comb begin
    mul_sum_c = {1'b0, p_q} + {1'b0, m_q & {WIDTH{q_q[0]}}};
    div_rsh_c = {p_q, q_q[WIDTH-1]};
    div_ge_c  = (div_rsh_c >= {1'b0, m_q});
    if (is_div_q) begin
      hi_step_c = div_ge_c ? WIDTH'(div_rsh_c - {1'b0, m_q}) : div_rsh_c[WIDTH-1:0];
      lo_step_c = {q_q[WIDTH-2:0], div_ge_c};
    end else begin
      hi_step_c = mul_sum_c[WIDTH:1];
      lo_step_c = {mul_sum_c[0], q_q[WIDTH-1:1]};
    end
  end

  // Final result. For a zero divisor the remainder path ends holding |A|, and
  // re-applying A's sign restores the original A, so only LO needs overriding.
  always_comb begin
    hi_res_c = hi_step_c;
    lo_res_c = lo_step_c;
`ifdef MDU_SIGNED_EN
    if (is_div_q) begin
      if (a_neg_q ^ b_neg_q) lo_res_c = -lo_step_c;
      if (a_neg_q)           hi_res_c = -hi_step_c;
    end else if (a_neg_q ^ b_neg_q) begin
      {hi_res_c, lo_res_c} = -{hi_step_c, lo_step_c};
    end
`endif
    if (div_zero_c) lo_res_c = '1;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start && (op_mul_c || op_div_c)) state_d = S_RUN;
      S_RUN:   if (cnt_q == '0) state_d = S_FIN;
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values
  always_comb begin
    cnt_d    = cnt_q;
    p_d      = p_q;
    q_d      = q_q;
    m_d      = m_q;
    is_div_d = is_div_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    dz_d     = dz_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
`ifdef MDU_SIGNED_EN
    a_neg_d  = a_neg_q;
    b_neg_d  = b_neg_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (op_mul_c || op_div_c) begin
            cnt_d    = CNT_W'(WIDTH - 1);
            p_d      = '0;
            q_d      = op_div_c ? a_mag_c : b_mag_c;
            m_d      = op_div_c ? b_mag_c : a_mag_c;
            is_div_d = op_div_c;
            busy_d   = 1'b1;
            dz_d     = 1'b0;
`ifdef MDU_SIGNED_EN
            a_neg_d  = a_neg_c;
            b_neg_d  = b_neg_c;
`endif
          end else if (op == OP_MTHI) begin
            hi_d = A;
          end else if (op == OP_MTLO) begin
            lo_d = A;
          end
        end
      end
      S_RUN: begin
        cnt_d = cnt_q - CNT_W'(1);
        p_d   = hi_step_c;
        q_d   = lo_step_c;
        if (cnt_q == '0) begin
          hi_d   = hi_res_c;
          lo_d   = lo_res_c;
          done_d = 1'b1;
          dz_d   = div_zero_c;
        end
      end
      S_FIN: busy_d = 1'b0;
      default: busy_d = 1'b0;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      p_q      <= '0;
      q_q      <= '0;
      m_q      <= '0;
      is_div_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
`ifdef MDU_SIGNED_EN
      a_neg_q  <= 1'b0;
      b_neg_q  <= 1'b0;
`endif
    end else begin
      cnt_q    <= cnt_d;
      p_q      <= p_d;
      q_q      <= q_d;
      m_q      <= m_d;
      is_div_q <= is_div_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      dz_q     <= dz_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
`ifdef MDU_SIGNED_EN
      a_neg_q  <= a_neg_d;
      b_neg_q  <= b_neg_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign dz   = dz_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed-vector bench for mul_div_unit (WIDTH=32); expected values follow MDU_SIGNED_EN.
module tb_mul_div_unit;
  localparam int unsigned W = 32;
`ifdef MDU_SIGNED_EN
  localparam bit SGN = 1'b1;
`else
  localparam bit SGN = 1'b0;
`endif
  localparam logic [2:0] MULTU = 3'b000, MULT = 3'b001, DIVU = 3'b010, DIV = 3'b011;
  localparam logic [2:0] MTHI = 3'b100, MTLO = 3'b101, NOP6 = 3'b110;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [2:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done, dz;
  logic [W-1:0] hi, lo;
  logic [W-1:0] h0, l0;
  int           n_cmp = 0;
  int           n_err = 0;

  mul_div_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .A(a), .B(b),
    .busy(busy), .done(done), .dz(dz), .HI(hi), .LO(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a, b, hi, lo;
    logic         dz;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Present a request for one cycle; returns in the cycle after the accepting edge.
  task automatic issue(input logic [2:0] o, input logic [W-1:0] av, input logic [W-1:0] bv);
    @(negedge clk);
    start = 1'b1; op = o; a = av; b = bv;
    h0 = hi; l0 = lo;
    @(negedge clk);
    start = 1'b0;
  endtask

  // lat counts cycles after the accepting edge; bounded so a stuck unit cannot hang the run.
  task automatic wait_done(input int lat0, output int lat, output int bcnt, output bit stable);
    lat = lat0; bcnt = 0; stable = 1'b1;
    while (!done && lat < 100) begin
      if (busy) bcnt++;
      if (hi !== h0 || lo !== l0) stable = 1'b0;
      @(negedge clk);
      lat++;
    end
    if (busy) bcnt++;
  endtask

  initial begin
    int lat, bcnt, seen;
    bit stable;

    vecs[0]  = '{MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[1]  = '{MULTU, 32'h0000FFFF, 32'h00000001, 32'h00000000, 32'h0000FFFF, 1'b0};
    vecs[2]  = '{MULTU, 32'h12345678, 32'h00000000, 32'h00000000, 32'h00000000, 1'b0};
    vecs[3]  = '{MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b0};
    vecs[4]  = '{DIVU,  32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 1'b0};
    vecs[5]  = '{DIVU,  32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF, 1'b1};
    vecs[6]  = '{DIVU,  32'h00000005, 32'h00000009, 32'h00000005, 32'h00000000, 1'b0};
    vecs[7]  = '{DIVU,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF, 1'b0};
    vecs[8]  = '{DIVU,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 1'b0};
    vecs[9]  = '{MULT,  32'hFFFFFFFE, 32'h00000003,
                 SGN ? 32'hFFFFFFFF : 32'h00000002, 32'hFFFFFFFA, 1'b0};
    vecs[10] = '{DIV,   32'hFFFFFFF9, 32'h00000002,
                 SGN ? 32'hFFFFFFFF : 32'h00000001, SGN ? 32'hFFFFFFFD : 32'h7FFFFFFC, 1'b0};
    vecs[11] = '{DIV,   32'h80000000, 32'hFFFFFFFF,
                 SGN ? 32'h00000000 : 32'h80000000, SGN ? 32'h80000000 : 32'h00000000, 1'b0};
    vecs[12] = '{MULT,  32'hFFFFFFFF, 32'hFFFFFFFF,
                 SGN ? 32'h00000000 : 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[13] = '{DIV,   32'h00000007, 32'hFFFFFFFE,
                 SGN ? 32'h00000001 : 32'h00000007, SGN ? 32'hFFFFFFFD : 32'h00000000, 1'b0};
    vecs[14] = '{DIV,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1};
    vecs[15] = '{MULT,  32'h80000000, 32'h00000002,
                 SGN ? 32'hFFFFFFFF : 32'h00000001, 32'h00000000, 1'b0};

    rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    chk("rst.busy", 64'(busy), 64'(1'b0));
    chk("rst.done", 64'(done), 64'(1'b0));
    chk("rst.dz",   64'(dz),   64'(1'b0));
    chk("rst.hi",   64'(hi),   64'h0);
    chk("rst.lo",   64'(lo),   64'h0);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_done(1, lat, bcnt, stable);
      chk($sformatf("v%0d.latency", i), 64'(lat),    64'(33));
      chk($sformatf("v%0d.busy_cyc", i), 64'(bcnt),  64'(33));
      chk($sformatf("v%0d.stable", i),  64'(stable), 64'(1'b1));
      chk($sformatf("v%0d.hi", i), 64'(hi), 64'(vecs[i].hi));
      chk($sformatf("v%0d.lo", i), 64'(lo), 64'(vecs[i].lo));
      chk($sformatf("v%0d.dz", i), 64'(dz), 64'(vecs[i].dz));
      @(negedge clk);
      chk($sformatf("v%0d.busy_after", i), 64'(busy), 64'(1'b0));
      chk($sformatf("v%0d.done_after", i), 64'(done), 64'(1'b0));
    end

    // dz holds in IDLE, then clears on the next accepted start
    issue(DIVU, 32'h00000007, 32'h00000000);
    wait_done(1, lat, bcnt, stable);
    chk("dz.with_done", 64'(dz), 64'(1'b1));
    repeat (2) @(negedge clk);
    chk("dz.holds", 64'(dz), 64'(1'b1));
    issue(MULTU, 32'h00000003, 32'h00000005);
    chk("dz.cleared", 64'(dz), 64'(1'b0));
    wait_done(1, lat, bcnt, stable);
    chk("dz.next.lo", 64'(lo), 64'h0000000F);

    // second start during RUN must be ignored
    issue(MULTU, 32'h0000FFFF, 32'h00000001);
    repeat (4) @(negedge clk);
    start = 1'b1; op = DIVU; a = 32'h00000064; b = 32'h00000007;
    @(negedge clk);
    start = 1'b0;
    wait_done(6, lat, bcnt, stable);
    chk("ign.latency", 64'(lat), 64'(33));
    chk("ign.hi", 64'(hi), 64'h0);
    chk("ign.lo", 64'(lo), 64'h0000FFFF);
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (busy) seen++;
    end
    chk("ign.no_rerun", 64'(seen), 64'(0));

    // MTHI then MTLO back to back, then a reserved opcode
    @(negedge clk);
    start = 1'b1; op = MTHI; a = 32'h12345678;
    @(negedge clk);
    chk("mthi.hi", 64'(hi), 64'h12345678);
    chk("mthi.busy", 64'(busy), 64'(1'b0));
    op = MTLO; a = 32'h9ABCDEF0;
    @(negedge clk);
    start = 1'b0;
    chk("mtlo.lo", 64'(lo), 64'h9ABCDEF0);
    chk("mtlo.hi", 64'(hi), 64'h12345678);
    chk("mtlo.done", 64'(done), 64'(1'b0));
    issue(NOP6, 32'hDEADBEEF, 32'h00000001);
    @(negedge clk);
    chk("op6.busy", 64'(busy), 64'(1'b0));
    chk("op6.hilo", {hi, lo}, 64'h12345678_9ABCDEF0);

    // reset in cycle 10 of a multiply discards it
    issue(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst.busy", 64'(busy), 64'(1'b0));
    chk("mrst.done", 64'(done), 64'(1'b0));
    chk("mrst.hilo", {hi, lo}, 64'h0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    chk("mrst.no_done", 64'(seen), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
